// File: rtl/s_term_uio_bridge_pkg.sv
// -----------------------------------------------------------------------------
// s_term_uio_bridge_pkg
// Shared definitions for the user-IO bridge:
//   - imode_e          : per-channel input conditioning mode encoding
//   - CFG_BITS_PER_CH  : configuration bits per channel (IMODE[1:0], OREG)
//   - CFG_IMODE_LSB    : bit offset of IMODE inside a channel's config field
//   - CFG_OREG_BIT     : bit offset of OREG inside a channel's config field
//   - calc_ncfgf()     : number of configuration frames needed for NCH channels
// -----------------------------------------------------------------------------
package s_term_uio_bridge_pkg;

    typedef enum logic [1:0] {
        IMODE_BYPASS = 2'b00,  // FIN = UIN, combinational
        IMODE_REG    = 2'b01,  // FIN = UIN delayed by one flop
        IMODE_SYNC   = 2'b10,  // FIN = two-flop synchronised UIN
        IMODE_EDGE   = 2'b11   // FIN = one-cycle pulse per UIN rising edge
    } imode_e;

    localparam int CFG_BITS_PER_CH = 3;
    localparam int CFG_IMODE_LSB   = 0;
    localparam int CFG_OREG_BIT    = 2;

    // Frames needed to cover 3*nch config bits, rounded up.
    function automatic int calc_ncfgf(input int nch, input int fbits);
        return (CFG_BITS_PER_CH * nch + fbits - 1) / fbits;
    endfunction

endpackage

// File: rtl/s_term_uio_bridge_uio_chan_cond.sv
// -----------------------------------------------------------------------------
// uio_chan_cond
// Conditioning for a single user-IO channel.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset, clears all flops
//   imode_i  : input conditioning mode (see imode_e)
//   oreg_i   : 1 = register the fabric-to-user path, 0 = pass through
//   uin_i    : user-project signal into the fabric
//   fin_o    : conditioned uin_i toward the switch matrix
//   fout_i   : switch-matrix signal toward the user project
//   uout_o   : conditioned fout_i toward the user project
// The s1/s2/s3/o1 flops run every cycle regardless of mode, so a mode change
// simply re-points the muxes at an already-filled pipeline.
// -----------------------------------------------------------------------------
module uio_chan_cond
    import s_term_uio_bridge_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  imode_e imode_i,
    input  logic   oreg_i,
    input  logic   uin_i,
    output logic   fin_o,
    input  logic   fout_i,
    output logic   uout_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic o1_q, o1_d;
    logic fin_s;
    logic uout_s;

    // Next state of the free-running input and output pipelines.
    always_comb begin
        s1_d = uin_i;
        s2_d = s1_q;
        s3_d = s2_q;
        o1_d = fout_i;
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            o1_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            o1_q <= o1_d;
        end
    end

    // Input-direction mode select; edge mode compares the synchronised
    // sample against the one behind it, so a level held high pulses once.
    always_comb begin
        fin_s = uin_i;
        case (imode_i)
            IMODE_BYPASS: fin_s = uin_i;
            IMODE_REG:    fin_s = s1_q;
            IMODE_SYNC:   fin_s = s2_q;
            IMODE_EDGE:   fin_s = s2_q & ~s3_q;
            default:      fin_s = uin_i;
        endcase
    end

    // Output-direction select between the live and the registered signal.
    always_comb begin
        uout_s = fout_i;
        if (oreg_i) begin
            uout_s = o1_q;
        end else begin
            uout_s = fout_i;
        end
    end

    assign fin_o  = fin_s;
    assign uout_o = uout_s;

endmodule

// File: rtl/s_term_uio_bridge.sv
// -----------------------------------------------------------------------------
// s_term_uio_bridge
// Bridge between a user project and the fabric switch matrix with per-channel
// configurable conditioning.
// Ports:
//   UserCLK       : clock, rising edge
//   RESET_N       : asynchronous active-low reset (release synchronised outside)
//   UserCLKo      : buffered UserCLK
//   FrameData     : configuration data word
//   FrameStrobe   : frame write strobes
//   FrameStrobe_O : buffered FrameStrobe
//   UIN / FIN     : user -> fabric signals, raw / conditioned
//   FOUT / UOUT   : fabric -> user signals, raw / conditioned
// Configuration: 3 bits per channel c, IMODE = CFG[3c+1:3c], OREG = CFG[3c+2].
// Frame CFG_FRAME_BASE+k loads CFG[k*FrameBitsPerRow +: FrameBitsPerRow];
// bits beyond 3*NCH have no storage and are dropped.
// -----------------------------------------------------------------------------
module s_term_uio_bridge
    import s_term_uio_bridge_pkg::*;
#(
    parameter int NCH             = 20,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME_BASE  = 0
) (
    input  logic                       UserCLK,
    input  logic                       RESET_N,
    output logic                       UserCLKo,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    input  logic [NCH-1:0]             UIN,
    output logic [NCH-1:0]             FIN,
    input  logic [NCH-1:0]             FOUT,
    output logic [NCH-1:0]             UOUT
);

    localparam int NCFGF = calc_ncfgf(NCH, FrameBitsPerRow);
    localparam int CFG_W = CFG_BITS_PER_CH * NCH;

    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] cfg_d;

    // Each stored config bit has exactly one owning frame; several strobes
    // high together therefore load their slices independently in one cycle.
    for (genvar k = 0; k < NCFGF; k++) begin : g_frame
        for (genvar b = 0; b < FrameBitsPerRow; b++) begin : g_bit
            if (k * FrameBitsPerRow + b < CFG_W) begin : g_used
                assign cfg_d[k*FrameBitsPerRow+b] =
                    FrameStrobe[CFG_FRAME_BASE+k] ? FrameData[b]
                                                  : cfg_q[k*FrameBitsPerRow+b];
            end
        end
    end

    // Configuration register; cleared to all-bypass by reset.
    always_ff @(posedge UserCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic [1:0] imode_s;
        logic       oreg_s;

        assign imode_s = cfg_q[CFG_BITS_PER_CH*c+CFG_IMODE_LSB +: 2];
        assign oreg_s  = cfg_q[CFG_BITS_PER_CH*c+CFG_OREG_BIT];

        uio_chan_cond u_chan (
            .clk_i   (UserCLK),
            .rst_ni  (RESET_N),
            .imode_i (imode_e'(imode_s)),
            .oreg_i  (oreg_s),
            .uin_i   (UIN[c]),
            .fin_o   (FIN[c]),
            .fout_i  (FOUT[c]),
            .uout_o  (UOUT[c])
        );
    end

    assign UserCLKo      = UserCLK;
    assign FrameStrobe_O = FrameStrobe;

endmodule

// File: tb/tb_s_term_uio_bridge.sv
// -----------------------------------------------------------------------------
// tb_s_term_uio_bridge
// Directed stimulus with hand-computed expectations. The stimulus process
// pushes the expected FIN/UOUT (and optionally FrameStrobe_O) for a given
// cycle into a scoreboard queue; a monitor on the falling edge compares every
// entry due in the current cycle.
// -----------------------------------------------------------------------------
module tb_s_term_uio_bridge;

    logic        UserCLK;
    logic        RESET_N;
    logic        UserCLKo;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic [19:0] FrameStrobe_O;
    logic [19:0] UIN;
    logic [19:0] FIN;
    logic [19:0] FOUT;
    logic [19:0] UOUT;

    s_term_uio_bridge #(
        .NCH             (20),
        .MaxFramesPerCol (20),
        .FrameBitsPerRow (32),
        .CFG_FRAME_BASE  (0)
    ) dut (
        .UserCLK       (UserCLK),
        .RESET_N       (RESET_N),
        .UserCLKo      (UserCLKo),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .FrameStrobe_O (FrameStrobe_O),
        .UIN           (UIN),
        .FIN           (FIN),
        .FOUT          (FOUT),
        .UOUT          (UOUT)
    );

    typedef struct packed {
        int          tcyc;
        logic [127:0] name;
        logic [19:0] fin_e;
        logic [19:0] uout_e;
        logic        chk_fs;
        logic [19:0] fs_e;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    // Cycle index: incremented at each rising edge.
    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge UserCLK);
        #2;
    endtask

    task automatic push_exp(input int t, input logic [127:0] nm,
                            input logic [19:0] fe, input logic [19:0] ue,
                            input logic chk, input logic [19:0] fse);
        exp_t e;
        e.tcyc   = t;
        e.name   = nm;
        e.fin_e  = fe;
        e.uout_e = ue;
        e.chk_fs = chk;
        e.fs_e   = fse;
        sb.push_back(e);
    endtask

    // Monitor: compare every scoreboard entry due in this cycle.
    always @(negedge UserCLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tcyc == cyc) begin
                checks = checks + 1;
                if (FIN !== sb[i].fin_e || UOUT !== sb[i].uout_e ||
                    UserCLKo !== 1'b0 ||
                    (sb[i].chk_fs && FrameStrobe_O !== sb[i].fs_e)) begin
                    errors = errors + 1;
                    $display("FAIL %0s cyc=%0d FIN=%05h want %05h UOUT=%05h want %05h FSO=%05h want %05h CLKO=%b",
                             sb[i].name, cyc, FIN, sb[i].fin_e, UOUT, sb[i].uout_e,
                             FrameStrobe_O, sb[i].fs_e, UserCLKo);
                end
                sb.delete(i);
            end
        end
    end

    // Scenario 2 vectors: all channels IMODE=00, OREG=1; UOUT = previous FOUT.
    logic [19:0] s2_uin  [4] = '{20'h33333, 20'h44444, 20'hA5A5A, 20'h5A5A5};
    logic [19:0] s2_fout [4] = '{20'h12345, 20'hFEDCB, 20'h00001, 20'h80000};
    logic [19:0] s2_uexp [4] = '{20'hABCDE, 20'h12345, 20'hFEDCB, 20'h00001};

    initial begin
        logic [11:0] u3_pat;
        logic [11:0] f0_pat;
        logic [11:0] f3_pat;
        logic [11:0] f11_pat;
        logic [11:0] fo_pat;
        logic [11:0] uo13_pat;
        logic [9:0]  r_u3_pat;
        logic [9:0]  r_f3_pat;
        logic [19:0] fe;
        logic [19:0] ue;

        RESET_N     = 1'b0;
        UIN         = 20'hA5A5A;
        FOUT        = 20'h5A5A5;
        FrameStrobe = 20'h00000;
        FrameData   = 32'h0000_0000;

        // ---- Reset: bypass in both directions, same cycle ----
        tick();
        push_exp(cyc, "rst_bypass_a", 20'hA5A5A, 20'h5A5A5, 1'b1, 20'h00000);
        tick();
        UIN  = 20'h12345;
        FOUT = 20'h6789A;
        push_exp(cyc, "rst_bypass_b", 20'h12345, 20'h6789A, 1'b0, 20'h00000);
        tick();
        RESET_N = 1'b1;
        UIN     = 20'hA5A5A;
        FOUT    = 20'h5A5A5;
        push_exp(cyc, "release_bypass", 20'hA5A5A, 20'h5A5A5, 1'b0, 20'h00000);

        // ---- OREG=1 on every channel, IMODE=00 ----
        // Frame 1 word 0x09249249 sets bit 0,3,..,27 -> OREG of channels 10..19.
        tick();
        FrameStrobe = 20'h00001;
        FrameData   = 32'h2492_4924;
        UIN         = 20'h11111;
        FOUT        = 20'h0F0F0;
        push_exp(cyc, "cfg0_strobe", 20'h11111, 20'h0F0F0, 1'b1, 20'h00001);
        tick();
        // Channels 0..9 registered already, 10..19 still live.
        FrameStrobe = 20'h00002;
        FrameData   = 32'h0924_9249;
        UIN         = 20'h22222;
        FOUT        = 20'hABCDE;
        push_exp(cyc, "cfg1_strobe_mixed", 20'h22222, 20'hABCF0, 1'b1, 20'h00002);
        for (int k = 0; k < 4; k++) begin
            tick();
            FrameStrobe = 20'h00000;
            UIN         = s2_uin[k];
            FOUT        = s2_fout[k];
            push_exp(cyc, "oreg_lag", s2_uin[k], s2_uexp[k], 1'b0, 20'h00000);
        end
        tick();
        UIN  = 20'h00000;
        FOUT = 20'h00000;
        push_exp(cyc, "oreg_tail", 20'h00000, 20'h80000, 1'b0, 20'h00000);
        tick();
        tick();

        // ---- Simultaneous frame 0+1 load, word 0xF0000602 in both slices ----
        // ch0 IMODE=10, ch3 IMODE=11, ch9 IMODE=10/OREG=1, ch10 IMODE=11,
        // ch11 IMODE=01, ch13 OREG=1, ch14 IMODE=01; frame-1 bits 28..31 dropped.
        tick();
        FrameStrobe = 20'h00003;
        FrameData   = 32'hF000_0602;
        push_exp(cyc, "cfg01_simul", 20'h00000, 20'h00000, 1'b1, 20'h00003);

        u3_pat   = 12'h09F;  // UIN[3]/UIN[11]: high k=0..4, k=7
        f0_pat   = 12'hFFC;  // FIN[0]: sync, high from k=2
        f3_pat   = 12'h204;  // FIN[3]: pulses at k=2 and k=9
        f11_pat  = 12'h13E;  // FIN[11]: UIN[11] one cycle late
        fo_pat   = 12'hAAA;  // FOUT[12]/[13] = k odd; UOUT[12] live
        uo13_pat = 12'h554;  // UOUT[13]: FOUT[13] one cycle late
        for (int k = 0; k < 12; k++) begin
            tick();
            FrameStrobe = 20'h00000;
            UIN         = 20'h00000;
            UIN[0]      = 1'b1;
            UIN[3]      = u3_pat[0];
            UIN[11]     = u3_pat[0];
            FOUT        = 20'h00000;
            FOUT[12]    = fo_pat[0];
            FOUT[13]    = fo_pat[0];
            fe          = 20'h00000;
            fe[0]       = f0_pat[0];
            fe[3]       = f3_pat[0];
            fe[11]      = f11_pat[0];
            ue          = 20'h00000;
            ue[12]      = fo_pat[0];
            ue[13]      = uo13_pat[0];
            push_exp(cyc, "modes_seq", fe, ue, 1'b0, 20'h00000);
            u3_pat   = u3_pat >> 1;
            f0_pat   = f0_pat >> 1;
            f3_pat   = f3_pat >> 1;
            f11_pat  = f11_pat >> 1;
            fo_pat   = fo_pat >> 1;
            uo13_pat = uo13_pat >> 1;
        end

        // ---- Reset one cycle after a UIN[3] rise in edge mode ----
        tick();
        UIN  = 20'h00008;
        FOUT = 20'h00000;
        tick();
        RESET_N = 1'b0;
        push_exp(cyc, "rst_midpulse", 20'h00008, 20'h00000, 1'b0, 20'h00000);
        tick();
        push_exp(cyc, "rst_hold", 20'h00008, 20'h00000, 1'b0, 20'h00000);
        tick();
        RESET_N = 1'b1;
        push_exp(cyc, "rst_release", 20'h00008, 20'h00000, 1'b0, 20'h00000);
        for (int k = 0; k < 2; k++) begin
            tick();
            push_exp(cyc, "post_release", 20'h00008, 20'h00000, 1'b0, 20'h00000);
        end
        tick();
        FrameStrobe = 20'h00001;
        FrameData   = 32'h0000_0600;
        push_exp(cyc, "reload_strobe", 20'h00008, 20'h00000, 1'b1, 20'h00001);

        r_u3_pat = 10'h023;  // UIN[3]: high j=0,1, low j=2..4, high j=5
        r_f3_pat = 10'h080;  // FIN[3]: single pulse at j=7
        for (int j = 0; j < 10; j++) begin
            tick();
            FrameStrobe = 20'h00000;
            UIN         = 20'h00000;
            UIN[3]      = r_u3_pat[0];
            fe          = 20'h00000;
            fe[3]       = r_f3_pat[0];
            push_exp(cyc, "reload_edge", fe, 20'h00000, 1'b0, 20'h00000);
            r_u3_pat = r_u3_pat >> 1;
            r_f3_pat = r_f3_pat >> 1;
        end

        tick();
        tick();
        tick();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
